// File: rtl/refclk_scan_pkg.sv
// Shared scan-state type and default constants for the reference-clock frequency scanner.
package refclk_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    REPORT = 2'd3
  } scan_state_e;

  localparam int DEF_NUM_CH        = 10;
  localparam int DEF_GATE_CYCLES   = 100000;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_CNT_W         = 16;
  localparam int FULL_PASS_PERIOD  = 16;
  localparam int PASS_W            = $clog2(FULL_PASS_PERIOD);

endpackage

// File: rtl/refclk_tog_sync.sv
// Two-flop synchroniser for one asynchronous divider-MSB toggle, plus a history
// flop giving a single-cycle pulse on each synchronised rising edge.
module refclk_tog_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tog_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Synchroniser chain and edge history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= tog_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/refclk_scan_ctrl.sv
// Round-robin gated edge counter over NUM_CH reference-clock toggles with a valid/ready result port.
// Optional macro REFCLK_SCAN_SKIP_DEAD_EN skips dead channels except on every 16th (full) pass.
module refclk_scan_ctrl
  import refclk_scan_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                      ref_clk_100M,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         tog_in,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [CNT_W-1:0]          res_cnt,
  output logic                      res_ovf,
  output logic [NUM_CH-1:0]         alive,
  output logic                      scan_done
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int GW  = $clog2(GATE_CYCLES + 1);
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);

  scan_state_e       state_q;
  logic [CHW-1:0]    ptr_q;
  logic [SW-1:0]     settle_q;
  logic [GW-1:0]     gate_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              res_valid_q;
  logic [CHW-1:0]    res_ch_q;
  logic [CNT_W-1:0]  res_cnt_q;
  logic              res_ovf_q;
  logic [NUM_CH-1:0] alive_q;
  logic              scan_done_q;
  logic [NUM_CH-1:0] rise_s;
  logic [CHW-1:0]    nxt_ptr_s;
  logic              wrap_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    refclk_tog_sync u_sync (
      .clk_i  (ref_clk_100M),
      .rst_i  (rst),
      .tog_i  (tog_in[g]),
      .rise_o (rise_s[g])
    );
  end

  // Saturating edge count including the current cycle's selected edge
  always_comb begin
    cnt_d = (rise_s[ptr_q] && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d = ovf_q | (cnt_d == '1);
  end

`ifdef REFCLK_SCAN_SKIP_DEAD_EN
  logic [PASS_W-1:0] pass_q;
  logic              full_s;
  logic              nxt_full_s;
  logic              hit_s;

  // Next channel: first eligible later in this pass, else first eligible of the next pass
  always_comb begin
    full_s     = (pass_q == PASS_W'(FULL_PASS_PERIOD - 1)) || (alive_q == '0);
    nxt_full_s = ((pass_q + PASS_W'(1)) == PASS_W'(FULL_PASS_PERIOD - 1)) || (alive_q == '0);
    nxt_ptr_s  = '0;
    wrap_s     = 1'b1;
    hit_s      = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      nxt_ptr_s = (nxt_full_s || alive_q[i]) ? CHW'(i) : nxt_ptr_s;
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      hit_s     = (i > int'(ptr_q)) && (full_s || alive_q[i]);
      nxt_ptr_s = hit_s ? CHW'(i) : nxt_ptr_s;
      wrap_s    = hit_s ? 1'b0 : wrap_s;
    end
  end
`else
  // Plain round-robin advance
  always_comb begin
    wrap_s    = (ptr_q == CHW'(NUM_CH - 1));
    nxt_ptr_s = wrap_s ? '0 : ptr_q + CHW'(1);
  end
`endif

  // Scan FSM with registered result port
  always_ff @(posedge ref_clk_100M or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      settle_q    <= '0;
      gate_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      alive_q     <= '0;
      scan_done_q <= 1'b0;
`ifdef REFCLK_SCAN_SKIP_DEAD_EN
      pass_q      <= '0;
`endif
    end else begin
      scan_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q  <= SETTLE;
            settle_q <= '0;
          end
        end
        SETTLE: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_q <= GATE;
            gate_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        GATE: begin
          if (!en) begin
            state_q <= IDLE;
          end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            gate_q <= gate_q + GW'(1);
            if (gate_q == GW'(GATE_CYCLES - 1)) begin
              res_ch_q       <= ptr_q;
              res_cnt_q      <= cnt_d;
              res_ovf_q      <= ovf_d;
              alive_q[ptr_q] <= (cnt_d != '0);
              res_valid_q    <= 1'b1;
              state_q        <= REPORT;
            end
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            ptr_q       <= nxt_ptr_s;
            scan_done_q <= wrap_s;
            settle_q    <= '0;
            state_q     <= en ? SETTLE : IDLE;
`ifdef REFCLK_SCAN_SKIP_DEAD_EN
            pass_q      <= wrap_s ? pass_q + PASS_W'(1) : pass_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_cnt   = res_cnt_q;
  assign res_ovf   = res_ovf_q;
  assign alive     = alive_q;
  assign scan_done = scan_done_q;

endmodule
